serial_to_parallel_receiver: RTL and testbench
==============================================

Name: serial_to_parallel_receiver

Overview:
- Serial-in/parallel-out receiver; the receiving end of the universal shift register's serial-out mode.
- Collects a frame of WIDTH+1 bits from a single serial line, one bit per enabled clock.
- Presents the assembled word on a parallel output with a one-cycle valid strobe.
- Sits between a serial link (or the shift register's serial output) and parallel consumer logic.

Parameters:
WIDTH, 15, MSB index of the data word; frame length N = WIDTH+1 bits (default 16).

Ports:
clk  input  1  system clock, all state on rising edge
res  input  1  reset, asynchronous, active-high
serial_in  input  1  serial data bit
start  input  1  frame start request, level-sampled on clk
sample_en  input  1  bit-rate enable; a bit is sampled only on edges where sample_en=1
lsb_first  input  1  bit order: 1 = first bit received is D[0], 0 = first bit is D[WIDTH]
out_data  output  WIDTH+1  last completed word, held until the next frame completes
valid  output  1  one-cycle pulse: out_data updated this cycle
busy  output  1  1 while in state SHIFT
err  output  1  one-cycle pulse: start request while busy (overrun)

Behaviour:
- Reset (res=1, asynchronous): state=IDLE, shift register=0, bit counter=0, out_data=0, valid=0, busy=0, err=0, latched order=1. Reset mid-frame discards the partial frame; out_data does not update.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at an edge -> SHIFT; bit counter cleared; lsb_first latched for the whole frame.
  - No bit is sampled on the start edge.
  - start=0 -> stay IDLE.
- SHIFT: on each edge with sample_en=1, one bit is taken and the counter increments.
  - Latched order 1: sr <= {serial_in, sr[WIDTH:1]}.
  - Latched order 0: sr <= {sr[WIDTH-1:0], serial_in}.
  - Edges with sample_en=0: sr, counter and state hold (stall, unbounded).
- Last bit (counter = WIDTH at an enabled edge):
  - out_data <= shifted value including the current serial_in; valid=1 for the following cycle only.
  - Next state is SHIFT (back-to-back frame, new order latched, counter cleared, no err) if start=1 on that edge; otherwise IDLE.
- Latency: with sample_en held at 1, start seen at edge k -> bits sampled at edges k+1..k+N -> valid high during the cycle after edge k+N.
- Overrun: start=1 in SHIFT on any edge other than the last-bit edge -> err=1 for one cycle; the frame continues unaffected; start is otherwise ignored.
- busy = (state==SHIFT).
- valid and err are registered.
- Latched lsb_first is immune to mid-frame changes of the lsb_first input.
- Counter width is sufficient for the count 0..WIDTH; no wrap inside a frame.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, then drive nothing -> out_data=16'h0000, valid=0, busy=0, err=0; assert res mid-frame at bit 7 -> busy=0 immediately, no valid, out_data unchanged.
- WIDTH=15, lsb_first=1, sample_en=1, start at edge 0, serial bits = 16'hA5C3 LSB first -> busy during edges 1-16, valid high for exactly one cycle after edge 16, out_data=16'hA5C3.
- Same word, lsb_first=0, MSB first -> out_data=16'hA5C3. Toggle the lsb_first input mid-frame -> result unchanged.
- sample_en pattern 1,0,0,1 repeated, word 16'h1234 LSB first -> out_data=16'h1234; valid appears after the 16th enabled edge; no extra bits taken during stalls.
- start pulsed at bit 5 of a frame -> err one-cycle pulse, frame completes with the correct word. start held high on the last-bit edge -> valid plus immediate second frame (16'hFFFF then 16'h0001), no err, busy stays 1.
- Cross-check against the universal shift register in serial-out mode (set=6, enable-loaded D=16'h5A5A, LSB first) -> receiver out_data=16'h5A5A.

Source files
------------

// File: rtl/serial_to_parallel_receiver.sv
// serial_to_parallel_receiver: collects WIDTH+1 serial bits per frame and presents them as a parallel word
module serial_to_parallel_receiver #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             res,
  input  logic             serial_in,
  input  logic             start,
  input  logic             sample_en,
  input  logic             lsb_first,
  output logic [WIDTH:0]   out_data,
  output logic             valid,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] sr_q, sr_d, out_q, out_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, err_q, err_d, order_q, order_d, last;
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      order_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      order_q <= order_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    order_d = order_q;
    shifted = order_q ? {serial_in, sr_q[WIDTH:1]} : {sr_q[WIDTH-1:0], serial_in};
    last    = sample_en && (cnt_q == CW'(WIDTH));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          order_d = lsb_first;
        end
      end
      SHIFT: begin
        // a start on the last-bit edge chains the next frame instead of flagging overrun
        err_d = start && !last;
        if (sample_en) begin
          sr_d  = shifted;
          cnt_d = cnt_q + 1'b1;
        end
        if (last) begin
          out_d   = shifted;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = start ? SHIFT : IDLE;
          order_d = start ? lsb_first : order_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign out_data = out_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign busy     = (state_q == SHIFT);
endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// tb_serial_to_parallel_receiver: table-driven and randomized frame checks against an ordering model
module tb_serial_to_parallel_receiver;
  logic clk = 1'b0, res = 1'b1, serial_in = 1'b0, start = 1'b0, sample_en = 1'b0, lsb_first = 1'b0;
  logic [15:0] out_data;
  logic valid, busy, err;
  int checks = 0, failures = 0, vcnt = 0, ecnt = 0;

  serial_to_parallel_receiver #(.WIDTH(15)) dut (
    .clk(clk), .res(res), .serial_in(serial_in), .start(start), .sample_en(sample_en),
    .lsb_first(lsb_first), .out_data(out_data), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (valid) vcnt++;
    if (err) ecnt++;
  end

  typedef struct {
    logic [15:0] w;
    bit          lsb;
    int          stall;
    bit          tog;
    int          err_bit;
    logic [15:0] exp;
    int          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rev(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  // s[t] is the bit driven at the t-th enabled edge; caller is at a negedge on entry and exit
  task automatic send(input logic [15:0] s, input bit lsb, input int stall, input bit tog,
                      input int err_bit, input bit chain, input bit no_start, output bit busy_ok);
    busy_ok = 1'b1;
    if (!no_start) begin
      start = 1'b1; lsb_first = lsb;
      sample_en = 1'($urandom); serial_in = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    for (int t = 0; t < 16; t++) begin
      int ns;
      ns = (stall == 1) ? (t % 2) * 2 : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < ns; k++) begin
        sample_en = 1'b0; serial_in = 1'($urandom); start = 1'b0;
        if (tog) lsb_first = ~lsb_first;
        if (!busy) busy_ok = 1'b0;
        @(negedge clk);
      end
      if (!busy) busy_ok = 1'b0;
      sample_en = 1'b1; serial_in = s[t];
      start = (t == err_bit) || (chain && t == 15);
      if (tog) lsb_first = ~lsb_first;
      if (chain && t == 15) lsb_first = lsb;
      @(negedge clk);
    end
    start = 1'b0; sample_en = 1'b0;
  endtask

  task automatic frame_check(input string name, input logic [15:0] exp, input int exp_err, input bit busy_ok);
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    chk({name, "_busy_during"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({name, "_valid_pulse"}, 32'(valid), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_valid_count"}, 32'(vcnt), 32'd1);
    chk({name, "_err_count"}, 32'(ecnt), 32'(exp_err));
  endtask

  initial begin
    vec_t vecs[6];
    bit bok;
    logic [15:0] s, exp;
    bit lsb;
    vecs[0] = '{16'hA5C3, 1'b1, 0, 1'b0, -1, 16'hA5C3, 0};
    vecs[1] = '{16'hA5C3, 1'b0, 0, 1'b0, -1, 16'hA5C3, 0};
    vecs[2] = '{16'hA5C3, 1'b0, 0, 1'b1, -1, 16'hA5C3, 0};
    vecs[3] = '{16'h1234, 1'b1, 1, 1'b0, -1, 16'h1234, 0};
    vecs[4] = '{16'h0F0F, 1'b1, 0, 1'b0, 5, 16'h0F0F, 1};
    vecs[5] = '{16'h5A5A, 1'b1, 0, 1'b1, -1, 16'h5A5A, 0};

    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out_data), 32'h0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    res = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    vcnt = 0;
    start = 1'b1; lsb_first = 1'b1;
    @(negedge clk);
    start = 1'b0; sample_en = 1'b1; serial_in = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    res = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_out", 32'(out_data), 32'h0);
    @(negedge clk);
    res = 1'b0; sample_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("async_rst_no_valid", 32'(vcnt), 32'd0);

    foreach (vecs[i]) begin
      vcnt = 0; ecnt = 0;
      send(vecs[i].lsb ? vecs[i].w : rev(vecs[i].w), vecs[i].lsb, vecs[i].stall, vecs[i].tog,
           vecs[i].err_bit, 1'b0, 1'b0, bok);
      frame_check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_err, bok);
      @(negedge clk);
    end

    vcnt = 0; ecnt = 0;
    send(16'hFFFF, 1'b1, 0, 1'b0, -1, 1'b1, 1'b0, bok);
    chk("chain1_valid", 32'(valid), 32'd1);
    chk("chain1_data", 32'(out_data), 32'hFFFF);
    chk("chain1_busy", 32'(busy), 32'd1);
    vcnt = 0;
    send(16'h0001, 1'b1, 0, 1'b0, -1, 1'b0, 1'b1, bok);
    frame_check("chain2", 16'h0001, 0, bok);

    for (int n = 0; n < 20; n++) begin
      s = 16'($urandom);
      lsb = 1'($urandom);
      exp = '0;
      for (int t = 0; t < 16; t++)
        if (lsb) exp = exp | (16'(s[t]) << t);
        else exp = exp | (16'(s[t]) << (15 - t));
      vcnt = 0; ecnt = 0;
      send(s, lsb, 2, 1'($urandom), (n % 4 == 0) ? int'($urandom_range(0, 14)) : -1, 1'b0, 1'b0, bok);
      frame_check($sformatf("rand%0d", n), exp, (n % 4 == 0) ? 1 : 0, bok);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
